// File: rtl/s3g_rx_multi.sv
// S3G packet receiver: arbitrates NCH byte streams, frames 0xD5/len/payload/CRC-8 packets,
// stores payload in a RAM and mirrors the first NWIN bytes into a flat window.
module s3g_rx_multi #(
    parameter int NCH     = 2,
    parameter int BUF_AW  = 8,
    parameter int MAX_LEN = 255,
    parameter int NWIN    = 16,
    parameter int TMO_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*NCH-1:0]    rx_data,
    input  logic [NCH-1:0]      rx_done,
    output logic                packet_done,
    output logic                packet_error,
    output logic [1:0]          err_code,
    output logic [3:0]          packet_src,
    output logic                buffer_valid,
    output logic [7:0]          payload_len,
    input  logic [BUF_AW-1:0]   buffer_addr,
    output logic [7:0]          buffer_data,
    output logic [8*NWIN-1:0]   win
);
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CRC} state_t;

    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [31:0] TMO_LAST  = 32'(TMO_CYC) - 32'd1;

    state_t            state;
    logic [3:0]        src;
    logic [7:0]        cnt;
    logic [7:0]        crc;
    logic [BUF_AW-1:0] wr_addr;
    logic [31:0]       tmo_cnt;
    logic [7:0]        mem [2**BUF_AW];

    logic              start;
    logic [3:0]        start_ch;
    logic              src_vld;
    logic [7:0]        src_byte;
    logic              tmo_hit;

    function automatic logic [7:0] crc8_next(input logic [7:0] d, input logic [7:0] c);
        logic [7:0] r;
        r = c ^ d;
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        return r;
    endfunction

    // Lowest-index 0xD5 strobe wins in idle; otherwise only the latched source is looked at.
    always_comb begin
        start    = 1'b0;
        start_ch = '0;
        src_vld  = 1'b0;
        src_byte = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!start && rx_done[i] && rx_data[8*i +: 8] == 8'hD5) begin
                start    = 1'b1;
                start_ch = 4'(i);
            end
            if (src == 4'(i)) begin
                src_vld  = rx_done[i];
                src_byte = rx_data[8*i +: 8];
            end
        end
    end

    assign tmo_hit = (TMO_CYC != 0) && (state != S_IDLE) && !src_vld && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            src          <= '0;
            cnt          <= '0;
            crc          <= '0;
            wr_addr      <= '0;
            tmo_cnt      <= '0;
            packet_done  <= 1'b0;
            packet_error <= 1'b0;
            err_code     <= '0;
            packet_src   <= '0;
            buffer_valid <= 1'b0;
            payload_len  <= '0;
            win          <= '0;
        end else begin
            packet_done  <= 1'b0;
            packet_error <= 1'b0;
            if (state == S_IDLE || (state != S_IDLE && src_vld))
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 32'd1;

            case (state)
                S_IDLE: if (start) begin
                    src   <= start_ch;
                    state <= S_LEN;
                end
                S_LEN: if (src_vld) begin
                    payload_len  <= src_byte;
                    buffer_valid <= 1'b0;
                    win          <= '0;
                    wr_addr      <= '0;
                    crc          <= '0;
                    if (src_byte == 8'd0) begin
                        state <= S_CRC;
                    end else if ({1'b0, src_byte} > MAX_LEN_W) begin
                        packet_error <= 1'b1;
                        err_code     <= 2'd2;
                        packet_src   <= src;
                        state        <= S_IDLE;
                    end else begin
                        cnt   <= src_byte;
                        state <= S_DATA;
                    end
                end
                S_DATA: if (src_vld) begin
                    wr_addr <= wr_addr + 1'b1;
                    cnt     <= cnt - 8'd1;
                    crc     <= crc8_next(src_byte, crc);
                    for (int unsigned k = 0; k < NWIN; k++)
                        if (32'(wr_addr) == k) win[8*k +: 8] <= src_byte;
                    if (cnt == 8'd1) state <= S_CRC;
                end
                S_CRC: if (src_vld) begin
                    packet_src <= src;
                    state      <= S_IDLE;
                    if (src_byte == crc) begin
                        packet_done  <= 1'b1;
                        buffer_valid <= 1'b1;
                        err_code     <= 2'd0;
                    end else begin
                        packet_error <= 1'b1;
                        err_code     <= 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (tmo_hit) begin
                packet_error <= 1'b1;
                err_code     <= 2'd3;
                packet_src   <= src;
                state        <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DATA && src_vld) mem[wr_addr] <= src_byte;
    end

    always_ff @(posedge clk) begin
        buffer_data <= mem[buffer_addr];
    end
endmodule
